// File: rtl/uart_defs.sv
// rtl/uart_defs.sv - shared UART constants, FSM encodings and helpers
package uart_defs;

    localparam int UART_DBITS        = 8;
    localparam int UART_BAUD_DIV_DEF = 868;

    // Parity sense: the received parity bit must equal XOR(data) ^ UART_PAR_EVEN
    localparam logic UART_PAR_EVEN = 1'b0;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter with sync clear and mid/half ticks
module uart_baud_cnt #(
    parameter int BAUD_DIV = 868,
    parameter int HALF_DIV = BAUD_DIV / 2,
    localparam int CW      = $clog2(BAUD_DIV)
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic clr,
    output logic mid_tick,
    output logic half_tick
);

    logic [CW-1:0] bcnt_q;
    logic [CW-1:0] bcnt_d;

    always_comb begin
        bcnt_d = bcnt_q + 1'b1;
        if (clr || bcnt_q == CW'(BAUD_DIV - 1)) begin
            bcnt_d = '0;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
        end
    end

    assign mid_tick  = (bcnt_q == CW'(BAUD_DIV - 1));
    assign half_tick = (bcnt_q == CW'(HALF_DIV - 1));

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - 8E1 UART receiver, MSB first; UART_RX_MAJ_EN selects 3-sample majority voting
module uart_rx_frame
    import uart_defs::*;
#(
    parameter int BAUD_DIV = UART_BAUD_DIV_DEF,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic                  clk_sys,
    input  logic                  rst_n,
    input  logic                  uart_rx,
    output logic [UART_DBITS-1:0] rx_data,
    output logic                  rx_vld,
    output logic                  rx_perr,
    output logic                  rx_ferr,
    output logic                  rx_busy
);

    logic                  sync1_q, rxs_q, rxs_prev_q;
    logic [2:0]            state_q, state_d;
    logic [2:0]            bidx_q, bidx_d;
    logic [UART_DBITS-1:0] shreg_q, shreg_d;
    logic                  pbit_q, pbit_d;
    logic [UART_DBITS-1:0] data_q, data_d;
    logic                  vld_q, vld_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  busy_q, busy_d;
    logic                  arm_q, arm_d;

    logic mid_tick, half_tick;
    logic start_tick, bit_tick, samp;
    logic cnt_clr;

    // Holding the counter at zero in IDLE keeps the START half-tick aligned to the edge
    assign cnt_clr = (state_d != state_q) || (state_q == ST_IDLE);

    uart_baud_cnt #(
        .BAUD_DIV (BAUD_DIV),
        .HALF_DIV (HALF_DIV)
    ) u_baud_cnt (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .clr       (cnt_clr),
        .mid_tick  (mid_tick),
        .half_tick (half_tick)
    );

`ifdef UART_RX_MAJ_EN
    logic rxs_prev2_q;
    logic half_p1_q;

    // Decide one cycle after the nominal mid using the two preceding samples
    assign start_tick = half_p1_q;
    assign bit_tick   = mid_tick;
    assign samp       = maj3(rxs_prev2_q, rxs_prev_q, rxs_q);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            rxs_prev2_q <= 1'b1;
            half_p1_q   <= 1'b0;
        end else begin
            rxs_prev2_q <= rxs_prev_q;
            half_p1_q   <= half_tick;
        end
    end
`else
    assign start_tick = half_tick;
    assign bit_tick   = mid_tick;
    assign samp       = rxs_q;
`endif

    always_comb begin
        state_d = state_q;
        bidx_d  = bidx_q;
        shreg_d = shreg_q;
        pbit_d  = pbit_q;
        data_d  = data_q;
        vld_d   = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        busy_d  = busy_q;
        arm_d   = arm_q;

        case (state_q)
            ST_IDLE: begin
                if (!arm_q && rxs_q) begin
                    arm_d = 1'b1;
                end
                if (arm_q && rxs_prev_q && !rxs_q) begin
                    state_d = ST_START;
                    busy_d  = 1'b1;
                end
            end
            ST_START: begin
                if (start_tick) begin
                    if (!samp) begin
                        state_d = ST_DATA;
                        bidx_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shreg_d = {shreg_q[UART_DBITS-2:0], samp};
                    bidx_d  = bidx_q + 1'b1;
                    if (bidx_q == 3'(UART_DBITS - 1)) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    pbit_d  = samp;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    data_d  = shreg_q;
                    perr_d  = ((^shreg_q) ^ UART_PAR_EVEN) != pbit_q;
                    ferr_d  = !samp;
                    vld_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                    // A low stop sample blocks new frames until the line is seen high
                    arm_d   = samp;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            bidx_q     <= '0;
            shreg_q    <= '0;
            pbit_q     <= 1'b0;
            data_q     <= '0;
            vld_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
            arm_q      <= 1'b1;
        end else begin
            sync1_q    <= uart_rx;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
            state_q    <= state_d;
            bidx_q     <= bidx_d;
            shreg_q    <= shreg_d;
            pbit_q     <= pbit_d;
            data_q     <= data_d;
            vld_q      <= vld_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
            arm_q      <= arm_d;
        end
    end

    assign rx_data = data_q;
    assign rx_vld  = vld_q;
    assign rx_perr = perr_q;
    assign rx_ferr = ferr_q;
    assign rx_busy = busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - directed self-checking bench for uart_rx_frame
module tb_uart_rx_frame;

    localparam int BD = 16;

    logic       clk_sys = 1'b0;
    logic       rst_n   = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_vld, rx_perr, rx_ferr, rx_busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int t_start;
    int busy_seen;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } strobe_t;

    strobe_t sq[$];

    uart_rx_frame #(.BAUD_DIV(BD)) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .uart_rx (uart_rx),
        .rx_data (rx_data),
        .rx_vld  (rx_vld),
        .rx_perr (rx_perr),
        .rx_ferr (rx_ferr),
        .rx_busy (rx_busy)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (rx_vld) begin
            sq.push_back('{data: rx_data, perr: rx_perr, ferr: rx_ferr, cyc: cyc});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    // Sends the first nslots slots of {start, d7..d0, parity, stop}
    task automatic send_bits(input logic [7:0] d, input logic par_flip, input logic stop_v,
                             input int nslots);
        logic [10:0] fr;
        fr = {1'b0, d, (^d) ^ par_flip, stop_v};
        t_start = cyc;
        for (int i = 0; i < nslots; i++) begin
            uart_rx = fr[10 - i];
            repeat (BD) @(negedge clk_sys);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_v);
        send_bits(d, par_flip, stop_v, 11);
        uart_rx = 1'b1;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        strobe_t s;
        if (sq.size() == 0) begin
            check({tag, "_present"}, 0, 1);
        end else begin
            s = sq.pop_front();
            check({tag, "_data"}, s.data, d);
            check({tag, "_perr"}, s.perr, pe);
            check({tag, "_ferr"}, s.ferr, fe);
        end
    endtask

    initial begin
        logic [7:0] bytes [4];
        strobe_t    s0, s1;
        bytes[0] = 8'h01; bytes[1] = 8'h23; bytes[2] = 8'h45; bytes[3] = 8'h89;

        repeat (4) @(negedge clk_sys);
        check("rst_data", rx_data, 8'h00);
        check("rst_vld",  rx_vld,  0);
        check("rst_perr", rx_perr, 0);
        check("rst_ferr", rx_ferr, 0);
        check("rst_busy", rx_busy, 0);
        rst_n = 1'b1;
        repeat (3 * BD) @(negedge clk_sys);

        // Four clean frames with long gaps
        for (int i = 0; i < 4; i++) begin
            send_frame(bytes[i], 1'b0, 1'b1);
            repeat (4) @(negedge clk_sys);
            check("clean_cnt", sq.size(), 1);
            if (i == 0 && sq.size() > 0) begin
                check("latency", ((sq[0].cyc - t_start) >= 170 && (sq[0].cyc - t_start) <= 174), 1);
            end
            pop_check("clean", bytes[i], 1'b0, 1'b0);
            repeat (200 * BD) @(negedge clk_sys);
            check("hold_data", rx_data, bytes[i]);
            check("hold_vld", rx_vld, 0);
        end

        // Inverted parity
        send_frame(8'h23, 1'b1, 1'b1);
        repeat (4) @(negedge clk_sys);
        pop_check("perr", 8'h23, 1'b1, 1'b0);
        repeat (20 * BD) @(negedge clk_sys);

        // Framing error followed by a held-low line
        send_bits(8'h45, 1'b0, 1'b0, 11);
        repeat (3 * BD) @(negedge clk_sys);
        pop_check("ferr", 8'h45, 1'b0, 1'b1);
        check("ferr_extra", sq.size(), 0);
        check("ferr_busy", rx_busy, 0);
        uart_rx = 1'b1;
        repeat (2 * BD) @(negedge clk_sys);
        check("ferr_after_high", sq.size(), 0);
        send_frame(8'h01, 1'b0, 1'b1);
        repeat (4) @(negedge clk_sys);
        pop_check("post_ferr", 8'h01, 1'b0, 1'b0);
        repeat (20 * BD) @(negedge clk_sys);

        // Short low glitch on an idle line
        uart_rx = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < BD / 4; i++) begin
            @(negedge clk_sys);
            if (rx_busy) busy_seen = 1;
        end
        uart_rx = 1'b1;
        for (int i = BD / 4; i < BD / 2 + 3; i++) begin
            @(negedge clk_sys);
            if (rx_busy) busy_seen = 1;
        end
        check("glitch_busy_seen", busy_seen, 1);
        check("glitch_busy_end", rx_busy, 0);
        repeat (20 * BD) @(negedge clk_sys);
        check("glitch_no_vld", sq.size(), 0);

        // Reset in the middle of data bit 4 of 0x89
        send_bits(8'h89, 1'b0, 1'b1, 4);
        uart_rx = 1'b0;
        repeat (BD / 2) @(negedge clk_sys);
        rst_n = 1'b0;
        @(negedge clk_sys);
        check("mid_rst_data", rx_data, 8'h00);
        check("mid_rst_vld",  rx_vld,  0);
        check("mid_rst_perr", rx_perr, 0);
        check("mid_rst_ferr", rx_ferr, 0);
        check("mid_rst_busy", rx_busy, 0);
        uart_rx = 1'b1;
        repeat (4 * BD) @(negedge clk_sys);
        rst_n = 1'b1;
        repeat (12 * BD) @(negedge clk_sys);
        check("mid_rst_no_vld", sq.size(), 0);
        send_frame(8'h23, 1'b0, 1'b1);
        repeat (4) @(negedge clk_sys);
        pop_check("post_rst", 8'h23, 1'b0, 1'b0);
        repeat (20 * BD) @(negedge clk_sys);

        // Back-to-back frames with no idle between them
        send_bits(8'h01, 1'b0, 1'b1, 11);
        send_frame(8'h45, 1'b0, 1'b1);
        repeat (4) @(negedge clk_sys);
        check("b2b_cnt", sq.size(), 2);
        if (sq.size() == 2) begin
            s0 = sq[0];
            s1 = sq[1];
            check("b2b_gap", s1.cyc - s0.cyc, 11 * BD);
        end
        pop_check("b2b_a", 8'h01, 1'b0, 1'b0);
        pop_check("b2b_b", 8'h45, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Serial receive front end of the FPGA. It consumes the `uart_rx` line driven by the host-side UART and turns each frame into a parallel byte with a one-cycle valid strobe.
- Frame format: 1 start bit (0), 8 data bits MSB first (bit7 down to bit0), 1 parity bit, 1 stop bit (1).
  - Parity bit = XOR of the 8 data bits (even parity).
- Downstream command decoders take `rx_data`/`rx_vld` directly.

Parameters:
- BAUD_DIV, 868, system clocks per bit (100 MHz / 115200); legal values are 16 and above.
- HALF_DIV, BAUD_DIV/2, clocks from the start-edge detect to the start-bit mid-sample.

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- uart_rx  in  1  asynchronous serial input; idles high
- rx_data  out  8  last received byte; held until the next frame completes
- rx_vld  out  1  one-clk_sys pulse when `rx_data`/`rx_perr`/`rx_ferr` update
- rx_perr  out  1  parity mismatch flag for the current `rx_data`
- rx_ferr  out  1  stop bit sampled 0 for the current `rx_data`
- rx_busy  out  1  high from start detect until the stop sample

Behaviour:
- Reset values: `rx_data`=0x00, `rx_vld`=0, `rx_perr`=0, `rx_ferr`=0, `rx_busy`=0. The state machine goes to IDLE and the synchroniser flops preset to 1.
- Reset mid-frame aborts the frame with no strobe.
- Input path: 2-FF synchroniser, then a third flop for edge detect. `rxs` is the synchronised line.
- Bit counter:
  - `bcnt` counts 0..BAUD_DIV-1 and reloads to 0 on every state entry.
  - "Mid" means `bcnt`==BAUD_DIV-1, except in START, where it is `bcnt`==HALF_DIV-1.
- States:
  - IDLE: on a falling edge of `rxs`, go to START and set `rx_busy`=1. With ARM=0 the falling edge is ignored (see STOP).
  - START: at mid, sample `rxs`. 0 → DATA with bit index 0. 1 → false start: back to IDLE, `rx_busy`=0, no strobe.
  - DATA: at each mid, `shreg` <= {`shreg`[6:0], `rxs`}. After the 8th sample, go to PARITY.
  - PARITY: at mid, `pbit` <= `rxs`, then go to STOP.
  - STOP: at mid, sample `rxs` and act in the same cycle:
    - `rx_data` <= `shreg`
    - `rx_perr` <= (^`shreg`) != `pbit`
    - `rx_ferr` <= !`rxs`
    - `rx_vld` <= 1 for the following cycle only
    - go to IDLE with `rx_busy`=0
- Re-arm rule:
  - If the stop sample is 1, ARM=1 immediately, so a start bit directly after the stop bit is caught.
  - If the stop sample is 0 (framing error or break), ARM=0 until `rxs` is seen high for one cycle. No new frame starts during a held-low line.
- Latency: `rx_vld` rises 10.5 bit periods + 4 clk_sys after the pin falling edge of the start bit (±1 cycle edge-detect uncertainty).
- Errors do not suppress `rx_vld`; the byte is always delivered with its flags.
- `rx_perr` and `rx_ferr` are overwritten on every strobe; they are not sticky.
- Flags and data are stable whenever `rx_vld` is 0.

Optional Feature:
- Macro: `UART_RX_MAJ_EN`.
- Defined:
  - Every data, parity and stop sample is the majority vote of `rxs` at mid-1, mid and mid+1. The state advances at mid+1, so all bit slots shift by one cycle and latency grows by 1 clk.
  - The start check uses the same 3-sample vote centred on HALF_DIV-1.
- Undefined: single sample at mid, as above.

Decomposition:
- Shared package/header `uart_defs`:
  - FSM state encodings IDLE/START/DATA/PARITY/STOP (3 bits)
  - UART_DBITS=8
  - default BAUD_DIV=868
  - parity-mode constant UART_PAR_EVEN
- Shared with the TX-side blocks.
- One natural sub-module: `uart_baud_cnt`. It holds the `bcnt` counter with sync clear and emits `mid_tick`/`half_tick`, and is reused by the future transmitter.

Test Plan:
- Stimulus: four frames 0x01, 0x23, 0x45, 0x89, correct parity, 200-bit-time gaps.
  - Response: four `rx_vld` pulses with `rx_data` 0x01, 0x23, 0x45, 0x89.
  - `rx_perr`=`rx_ferr`=0 on all four; the 0x89 frame carries parity bit 1.
- Stimulus: 0x23 sent with parity bit inverted (0 instead of 1).
  - Response: `rx_vld` with `rx_data`=0x23, `rx_perr`=1, `rx_ferr`=0.
- Stimulus: 0x45 sent with stop bit 0, line held low 3 bit times, then high, then 0x01.
  - Response: one strobe with 0x45 and `rx_ferr`=1; no strobe during the low hold; then 0x01 with clean flags.
- Stimulus: low glitch of BAUD_DIV/4 clocks on an idle line.
  - Response: `rx_busy` pulses, no `rx_vld`, and the FSM returns to IDLE by HALF_DIV+3 clocks.
- Stimulus: `rst_n` asserted during data bit 4 of 0x89, released, then 0x23 sent.
  - Response: all outputs read 0 during reset, no strobe for the aborted frame, and 0x23 is received cleanly.
- Stimulus: frames 0x01 then 0x45 back-to-back with zero idle after the stop bit.
  - Response: two strobes exactly 11 bit periods apart with correct data.
